// File: rtl/reset_sequencer_if.sv
// Reset sequencer control/status bundle.
// master drives sources and requests; slave returns domain resets and cause.
interface reset_sequencer_if #(
   parameter int NUM_SRC     = 4,
   parameter int NUM_DOMAINS = 3
);
   logic [NUM_SRC-1:0]     io_src;
   logic [2*NUM_SRC-1:0]   io_srcMode;
   logic                   io_swReset;
   logic                   io_pllLocked;
   logic                   io_causeClear;
   logic [NUM_DOMAINS-1:0] io_domainReset;
   logic [NUM_SRC+1:0]     io_resetCause;
   logic                   io_busy;

   modport master (
      output io_src, io_srcMode, io_swReset,
      output io_pllLocked, io_causeClear,
      input  io_domainReset, io_resetCause, io_busy
   );

   modport slave (
      input  io_src, io_srcMode, io_swReset,
      input  io_pllLocked, io_causeClear,
      output io_domainReset, io_resetCause, io_busy
   );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: syncs/debounces reset sources, stretches, releases domains in order.
// Ports: io_mainClk, io_asyncReset_n (async active-low), bus (slave: sources in, resets/cause/busy out).
module reset_sequencer #(
   parameter int NUM_SRC         = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STRETCH_CYCLES  = 64,
   parameter int NUM_DOMAINS     = 3,
   parameter int DOMAIN_GAP      = 8
) (
   input  logic               io_mainClk,
   input  logic               io_asyncReset_n,
   reset_sequencer_if.slave   bus
);

   localparam int ARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int AMW = $clog2(ARM_CYCLES + 1);
   localparam int STW = $clog2(STRETCH_CYCLES + 1);
   localparam int GPW = $clog2(DOMAIN_GAP + 1);

   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [AMW-1:0] AM_LAST = AMW'(ARM_CYCLES - 1);
   localparam logic [STW-1:0] ST_LAST = STW'(STRETCH_CYCLES - 1);
   localparam logic [GPW-1:0] GP_LAST = GPW'(DOMAIN_GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ASSERT,
      S_RELEASE
   } state_t;

   logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_srcSync;
   logic [SYNC_STAGES-1:0]              r_pllSync;
   logic [NUM_SRC-1:0]                  r_deb;
   logic [NUM_SRC-1:0]                  r_debPrev;
   logic [DBW-1:0]                      r_dbCnt [NUM_SRC];
   logic [AMW-1:0]                      r_armCnt;
   logic                                r_armed;

   state_t                 r_state;
   logic [NUM_DOMAINS-1:0] r_dom;
   logic                   r_busy;
   logic [STW-1:0]         r_stretch;
   logic [GPW-1:0]         r_gap;
   logic [NUM_SRC+1:0]     r_cause;

   logic [NUM_SRC-1:0]     w_srcSynced;
   logic                   w_pllTrig;
   logic [NUM_SRC-1:0]     w_srcTrig;
   logic                   w_trig;
   logic [NUM_DOMAINS-1:0] w_domNext;

   assign w_srcSynced = r_srcSync[SYNC_STAGES-1];
   assign w_pllTrig   = ~r_pllSync[SYNC_STAGES-1];
   assign w_trig      = (|w_srcTrig) | bus.io_swReset | w_pllTrig;
   // Releasing bit 0 first is a left shift with zero fill.
   assign w_domNext   = r_dom << 1;

   always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
      if (!io_asyncReset_n) begin
         r_srcSync <= '0;
         r_pllSync <= '0;
      end else begin
         r_srcSync <= {r_srcSync[SYNC_STAGES-2:0], bus.io_src};
         r_pllSync <= {r_pllSync[SYNC_STAGES-2:0], bus.io_pllLocked};
      end
   end

   // Startup window: debounced values track the synced inputs so
   // power-up levels never look like edges.
   always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
      if (!io_asyncReset_n) begin
         r_armCnt <= '0;
         r_armed  <= 1'b0;
      end else if (!r_armed) begin
         if (r_armCnt == AM_LAST) begin
            r_armed <= 1'b1;
         end else begin
            r_armCnt <= r_armCnt + 1'b1;
         end
      end
   end

   always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
      if (!io_asyncReset_n) begin
         r_deb     <= '0;
         r_debPrev <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            r_dbCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!r_armed) begin
               r_deb[i]     <= w_srcSynced[i];
               r_debPrev[i] <= w_srcSynced[i];
               r_dbCnt[i]   <= '0;
            end else begin
               r_debPrev[i] <= r_deb[i];
               if (w_srcSynced[i] == r_deb[i]) begin
                  r_dbCnt[i] <= '0;
               end else if (r_dbCnt[i] == DB_LAST) begin
                  r_deb[i]   <= ~r_deb[i];
                  r_dbCnt[i] <= '0;
               end else begin
                  r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
               end
            end
         end
      end
   end

   // Edges come from the registered debounced history, so a mode
   // change alone can never fabricate one.
   always_comb begin
      w_srcTrig = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         unique case (bus.io_srcMode[2*i +: 2])
            2'b01:   w_srcTrig[i] = r_deb[i];
            2'b10:   w_srcTrig[i] = r_deb[i] & ~r_debPrev[i];
            2'b11:   w_srcTrig[i] = ~r_deb[i] & r_debPrev[i];
            default: w_srcTrig[i] = 1'b0;
         endcase
      end
      w_srcTrig = w_srcTrig & {NUM_SRC{r_armed}};
   end

   // New triggers are OR-ed in after the clear, so set beats clear.
   always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
      if (!io_asyncReset_n) begin
         r_cause <= '0;
      end else begin
         r_cause <= (bus.io_causeClear ? '0 : r_cause)
                  | {w_pllTrig, bus.io_swReset, w_srcTrig};
      end
   end

   always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
      if (!io_asyncReset_n) begin
         r_state   <= S_ASSERT;
         r_dom     <= '1;
         r_busy    <= 1'b1;
         r_stretch <= '0;
         r_gap     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_trig) begin
                  r_state   <= S_ASSERT;
                  r_dom     <= '1;
                  r_busy    <= 1'b1;
                  r_stretch <= '0;
               end
            end
            S_ASSERT: begin
               if (w_trig) begin
                  r_stretch <= '0;
               end else if (r_stretch == ST_LAST) begin
                  r_dom <= w_domNext;
                  r_gap <= '0;
                  // Single-domain builds drop straight back to idle.
                  if (w_domNext == '0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_RELEASE;
                  end
               end else begin
                  r_stretch <= r_stretch + 1'b1;
               end
            end
            S_RELEASE: begin
               if (w_trig) begin
                  r_state   <= S_ASSERT;
                  r_dom     <= '1;
                  r_stretch <= '0;
               end else if (r_gap == GP_LAST) begin
                  r_gap <= '0;
                  r_dom <= w_domNext;
                  if (w_domNext == '0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            default: begin
               r_state <= S_ASSERT;
               r_dom   <= '1;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.io_domainReset = r_dom;
   assign bus.io_resetCause  = r_cause;
   assign bus.io_busy        = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed stimulus queues expected output changes.
// A negedge monitor pops and compares each observed change (value and cycle window).
module tb_reset_sequencer;

   typedef struct {
      logic [3:0] val;
      int         lo;
      int         hi;
   } dexp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_pass;
   int   n_total;

   dexp_t      dq[$];
   logic [5:0] cq[$];

   logic [3:0] d_last;
   logic [5:0] c_last;
   bit         d_seen;
   bit         c_seen;

   reset_sequencer_if #(.NUM_SRC(4), .NUM_DOMAINS(3)) bus ();

   reset_sequencer #(
      .NUM_SRC(4),
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(16),
      .STRETCH_CYCLES(64),
      .NUM_DOMAINS(3),
      .DOMAIN_GAP(8)
   ) dut (
      .io_mainClk(clk),
      .io_asyncReset_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every change of outputs consumes one expectation.
   always @(negedge clk) begin
      logic [3:0] cur;
      dexp_t      e;
      cur = {bus.io_domainReset, bus.io_busy};
      if (!d_seen || cur != d_last) begin
         n_total++;
         if (dq.size() == 0) begin
            $display("FAIL dom_unexpected: got dom/busy=%b at cyc %0d, required no change",
                     cur, cyc);
         end else begin
            e = dq.pop_front();
            if (cur != e.val || cyc < e.lo || cyc > e.hi) begin
               $display("FAIL dom_change: got dom/busy=%b at cyc %0d, required %b in cyc %0d..%0d",
                        cur, cyc, e.val, e.lo, e.hi);
            end else begin
               n_pass++;
            end
         end
         d_last = cur;
         d_seen = 1'b1;
      end
      if (!c_seen || bus.io_resetCause != c_last) begin
         n_total++;
         if (cq.size() == 0) begin
            $display("FAIL cause_unexpected: got cause=%h at cyc %0d, required no change",
                     bus.io_resetCause, cyc);
         end else begin
            logic [5:0] ce;
            ce = cq.pop_front();
            if (bus.io_resetCause != ce) begin
               $display("FAIL cause_change: got cause=%h at cyc %0d, required %h",
                        bus.io_resetCause, cyc, ce);
            end else begin
               n_pass++;
            end
         end
         c_last = bus.io_resetCause;
         c_seen = 1'b1;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic push_d(input logic [3:0] v, input int lo, input int hi);
      dexp_t e;
      e.val = v;
      e.lo  = lo;
      e.hi  = hi;
      dq.push_back(e);
   endtask

   task automatic push_c(input logic [5:0] v);
      cq.push_back(v);
   endtask

   task automatic pulse_sw();
      bus.io_swReset = 1'b1;
      step(1);
      bus.io_swReset = 1'b0;
   endtask

   initial begin
      int t;
      n_pass  = 0;
      n_total = 0;
      d_seen  = 1'b0;
      c_seen  = 1'b0;
      rst_n   = 1'b0;
      bus.io_src        = '0;
      bus.io_srcMode    = '0;
      bus.io_swReset    = 1'b0;
      bus.io_pllLocked  = 1'b1;
      bus.io_causeClear = 1'b0;

      // Reset state
      push_d(4'b1111, 0, 3);
      push_c(6'h00);
      step(3);

      // Power-up release: PLL sync clears after 2 cycles
      t = cyc;
      push_d(4'b1101, t + 66, t + 66);
      push_d(4'b1001, t + 74, t + 74);
      push_d(4'b0000, t + 82, t + 82);
      push_c(6'h20);
      rst_n = 1'b1;
      wait_until(t + 100);

      // Source 1 falling-edge mode, glitch then real drop
      bus.io_srcMode = 8'b0000_1100;
      step(1);
      bus.io_src[1] = 1'b1;
      step(40);
      bus.io_src[1] = 1'b0;
      step(10);
      bus.io_src[1] = 1'b1;
      step(40);
      t = cyc;
      push_d(4'b1111, t + 18, t + 20);
      push_d(4'b1101, t + 82, t + 84);
      push_d(4'b1001, t + 90, t + 92);
      push_d(4'b0000, t + 98, t + 100);
      push_c(6'h22);
      bus.io_src[1] = 1'b0;
      wait_until(t + 120);

      // Source 0 level-high held 200 cycles
      bus.io_srcMode = 8'b0000_0001;
      step(1);
      t = cyc;
      push_d(4'b1111, t + 18, t + 20);
      push_c(6'h23);
      bus.io_src[0] = 1'b1;
      wait_until(t + 200);
      t = cyc;
      push_d(4'b1101, t + 81, t + 83);
      push_d(4'b1001, t + 89, t + 91);
      push_d(4'b0000, t + 97, t + 99);
      bus.io_src[0] = 1'b0;
      wait_until(t + 120);
      bus.io_srcMode = '0;

      // Software reset, then again mid-release
      step(1);
      t = cyc;
      push_d(4'b1111, t + 1, t + 1);
      push_d(4'b1101, t + 65, t + 65);
      push_c(6'h33);
      pulse_sw();
      wait_until(t + 68);
      t = cyc;
      push_d(4'b1111, t + 1, t + 1);
      push_d(4'b1101, t + 65, t + 65);
      push_d(4'b1001, t + 73, t + 73);
      push_d(4'b0000, t + 81, t + 81);
      pulse_sw();
      wait_until(t + 100);

      // Clear together with software reset: set wins
      t = cyc;
      push_d(4'b1111, t + 1, t + 1);
      push_d(4'b1101, t + 65, t + 65);
      push_d(4'b1001, t + 73, t + 73);
      push_d(4'b0000, t + 81, t + 81);
      push_c(6'h10);
      bus.io_swReset    = 1'b1;
      bus.io_causeClear = 1'b1;
      step(1);
      bus.io_swReset    = 1'b0;
      bus.io_causeClear = 1'b0;
      wait_until(t + 100);
      push_c(6'h00);
      bus.io_causeClear = 1'b1;
      step(1);
      bus.io_causeClear = 1'b0;
      step(5);

      // One-cycle PLL lock loss
      t = cyc;
      push_d(4'b1111, t + 3, t + 3);
      push_d(4'b1101, t + 67, t + 67);
      push_d(4'b1001, t + 75, t + 75);
      push_d(4'b0000, t + 83, t + 83);
      push_c(6'h20);
      bus.io_pllLocked = 1'b0;
      step(1);
      bus.io_pllLocked = 1'b1;
      wait_until(t + 100);

      // Async reset mid-release
      t = cyc;
      push_d(4'b1111, t + 3, t + 3);
      push_d(4'b1101, t + 67, t + 67);
      bus.io_pllLocked = 1'b0;
      step(1);
      bus.io_pllLocked = 1'b1;
      wait_until(t + 70);
      t = cyc;
      push_d(4'b1111, t, t);
      push_c(6'h00);
      rst_n = 1'b0;
      step(3);
      t = cyc;
      push_d(4'b1101, t + 66, t + 66);
      push_d(4'b1001, t + 74, t + 74);
      push_d(4'b0000, t + 82, t + 82);
      push_c(6'h20);
      rst_n = 1'b1;
      wait_until(t + 100);
      step(5);

      while (dq.size() > 0) begin
         dexp_t e;
         e = dq.pop_front();
         n_total++;
         $display("FAIL dom_missing: got no change, required %b in cyc %0d..%0d",
                  e.val, e.lo, e.hi);
      end
      while (cq.size() > 0) begin
         logic [5:0] ce;
         ce = cq.pop_front();
         n_total++;
         $display("FAIL cause_missing: got no change, required %h", ce);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
